score_judge: RTL and testbench
==============================

Name: score_judge

Overview:
Parametrised successor of the flappy-bird collision/point logic. Judges each game step (tick) on a ROWS-tall column:
- awards points when a pipe clears the bird column;
- detects bird/pipe and bird/ground collisions;
- manages a multi-life budget with post-hit invulnerability (grace).

Sits between the bird/pipe column generators and the score display / game-control FSM.

Parameters:
ROWS, 8, rows in the bird column; bit 0 is the ground row.
LIVES, 3, lives per game (>=1).
GRACE_TICKS, 4, ticks of invulnerability after a non-fatal hit (>=1).
SCORE_W, 10, score counter width.
GROUND_FATAL, 1, 1: ground contact ends the game regardless of lives; 0: ground contact costs one life like a pipe hit.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
ongoing  input  1  game running; low forces IDLE and clears game state.
tick  input  1  one-cycle game-step strobe; judging happens only on tick cycles.
bird  input  ROWS  one-hot bird position in the column.
pipe  input  ROWS  pipe occupancy of the bird column (all-zero = no pipe).
add_point  output  1  one-cycle pulse, point awarded.
hit  output  1  one-cycle pulse, a life was lost (also pulses on the fatal hit).
fail  output  1  level, game over; held until ongoing drops or reset.
invuln  output  1  level, high during GRACE.
lives  output  $clog2(LIVES+1)  remaining lives.
score  output  SCORE_W  points this game, saturating.

Behaviour:
- Reset (reset==0, synchronous): state=IDLE, prev_pipe=0, lives=LIVES, score=0, grace_cnt=0, add_point=hit=fail=invuln=0.
- All outputs are registered. The response to a tick in cycle N is visible in cycle N+1.
- States: IDLE, PLAY, GRACE, OVER.
  - IDLE: outputs as reset. ongoing=1 -> PLAY next cycle. A tick in the transition cycle is ignored.
  - ongoing=0 in any state -> IDLE next cycle with full clear, including fail.
  - Inputs are evaluated only on tick cycles. Non-tick cycles hold all state; add_point and hit are 0.
- Collision terms on a tick:
  - pipe_col = |(bird & pipe) over rows 1..ROWS-1.
  - ground_col = bird[0].
- PLAY, on tick:
  - ground_col & GROUND_FATAL -> lives=0, hit=1, fail=1, OVER.
  - Otherwise, if pipe_col|ground_col: lives-1 and hit=1.
    - New lives==0 -> OVER, fail=1.
    - Else -> GRACE, grace_cnt=GRACE_TICKS, invuln=1.
- GRACE, on tick:
  - Collisions are ignored, except fatal ground when GROUND_FATAL=1, which goes to OVER.
  - grace_cnt decrements. Reaching 0 -> PLAY, invuln=0.
  - GRACE lasts exactly GRACE_TICKS ticks.
- OVER: fail=1. Ticks are ignored, score and lives frozen. Exit only via ongoing=0 or reset.
- Point rule (PLAY or GRACE, on tick): prev_pipe!=0 and pipe==0 -> add_point=1, score+1.
  - score saturates at 2^SCORE_W-1 (add_point still pulses).
  - prev_pipe<=pipe on every tick in PLAY/GRACE; prev_pipe is cleared in IDLE.
- Simultaneous point and collision on one tick:
  - If the collision sends the FSM to OVER, no point is awarded.
  - Otherwise both apply: add_point=1 and hit=1 in the same cycle.
- Reset mid-game dominates ongoing and tick.

Decomposition:
- Package score_judge_pkg holds:
  - enum state_t {IDLE, PLAY, GRACE, OVER};
  - localparam GROUND_ROW=0.
- Sub-module pipe_pass_detect (parameter ROWS) holds prev_pipe and produces a combinational pass strobe qualified by tick and an enable. score_judge registers add_point from it.

Test Plan (defaults unless stated):
1. Reset low 2 cycles, then high with ongoing=0 -> lives=3, score=0, fail=0, all pulses 0. Tick with bird=8'h10 -> no change.
2. ongoing=1; tick with pipe=8'hEF, bird=8'h10; tick with pipe=0 -> add_point pulses 1 cycle after the second tick, score=1, hit=0.
3. Tick with bird=8'h10, pipe=8'h10 -> hit pulse, lives=2, invuln=1. Three more ticks with the same collision -> no hit, lives=2. Fourth tick -> invuln=0. Next colliding tick -> lives=1.
4. From lives=1, colliding tick -> hit=1, fail=1, lives=0. Further ticks keep score and lives frozen. ongoing=0 -> fail=0, lives=3, score=0.
5. GROUND_FATAL=1, bird=8'h01 on a tick in PLAY with lives=3 -> fail=1, lives=0. Repeat with GROUND_FATAL=0 -> lives=2, GRACE entered.
6. SCORE_W=2: four point events -> score 1,2,3,3 with add_point pulsing each time. Reset asserted mid-GRACE -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/score_judge_pkg.sv
// Shared types for the score judge: FSM state encoding and column row constants.
package score_judge_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, GRACE, OVER} state_t;
    localparam int GROUND_ROW = 0;
endpackage

// File: rtl/score_judge_if.sv
// Game-step bus between column generators, the judge and score/control consumers.
interface score_judge_if #(
    parameter int ROWS    = 8,
    parameter int LIVES   = 3,
    parameter int SCORE_W = 10
);
    localparam int LW = $clog2(LIVES + 1);

    logic               ongoing;
    logic               tick;
    logic [ROWS-1:0]    bird;
    logic [ROWS-1:0]    pipe;
    logic               add_point;
    logic               hit;
    logic               fail;
    logic               invuln;
    logic [LW-1:0]      lives;
    logic [SCORE_W-1:0] score;

    modport master (output ongoing, tick, bird, pipe,
                    input  add_point, hit, fail, invuln, lives, score);
    modport slave  (input  ongoing, tick, bird, pipe,
                    output add_point, hit, fail, invuln, lives, score);
endinterface

// File: rtl/score_judge_pipe_pass_detect.sv
// Remembers the pipe seen on the previous judged tick; strobes when a pipe has just left the column.
module pipe_pass_detect #(
    parameter int ROWS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic            tick_i,
    input  logic [ROWS-1:0] pipe_i,
    output logic            pass_o
);
    logic [ROWS-1:0] prev_pipe_q, prev_pipe_d;

    always_comb begin
        prev_pipe_d = prev_pipe_q;
        if (clr_i)              prev_pipe_d = '0;
        else if (tick_i && en_i) prev_pipe_d = pipe_i;
    end

    always_ff @(posedge clk) begin
        if (!reset) prev_pipe_q <= '0;
        else        prev_pipe_q <= prev_pipe_d;
    end

    assign pass_o = tick_i && en_i && (|prev_pipe_q) && !(|pipe_i);
endmodule

// File: rtl/score_judge.sv
// Per-tick collision, point and life judge with post-hit grace window.
module score_judge
    import score_judge_pkg::*;
#(
    parameter int ROWS         = 8,
    parameter int LIVES        = 3,
    parameter int GRACE_TICKS  = 4,
    parameter int SCORE_W      = 10,
    parameter int GROUND_FATAL = 1
) (
    input  logic         clk,
    input  logic         reset,
    score_judge_if.slave bus
);
    localparam int LW = $clog2(LIVES + 1);
    localparam int GW = $clog2(GRACE_TICKS + 1);

    state_t             state_q, state_d;
    logic [LW-1:0]      lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [GW-1:0]      grace_q, grace_d;
    logic               add_q, add_d;
    logic               hit_q, hit_d;
    logic               pass;
    logic               judging;

    // Row 0 is ground; a pipe segment there never counts as a pipe collision.
    wire pipe_col   = |(bus.bird[ROWS-1:1] & bus.pipe[ROWS-1:1]);
    wire ground_col = bus.bird[GROUND_ROW];

    assign judging = bus.ongoing && (state_q == PLAY || state_q == GRACE);

    pipe_pass_detect #(.ROWS(ROWS)) u_pass (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (!bus.ongoing || state_q == IDLE),
        .en_i   (judging),
        .tick_i (bus.tick),
        .pipe_i (bus.pipe),
        .pass_o (pass)
    );

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        grace_d = grace_q;
        add_d   = 1'b0;
        hit_d   = 1'b0;
        if (!bus.ongoing) begin
            state_d = IDLE;
            lives_d = LW'(LIVES);
            score_d = '0;
            grace_d = '0;
        end else if (bus.tick && judging) begin
            if (ground_col && GROUND_FATAL != 0) begin
                state_d = OVER;
                lives_d = '0;
                hit_d   = 1'b1;
            end else if (state_q == PLAY && (pipe_col || ground_col)) begin
                hit_d   = 1'b1;
                lives_d = lives_q - LW'(1);
                if (lives_q == LW'(1)) begin
                    state_d = OVER;
                end else begin
                    state_d = GRACE;
                    grace_d = GW'(GRACE_TICKS);
                end
            end else if (state_q == GRACE) begin
                grace_d = grace_q - GW'(1);
                if (grace_q == GW'(1)) state_d = PLAY;
            end
            // A game-ending hit swallows a point scored on the same tick.
            if (pass && state_d != OVER) begin
                add_d = 1'b1;
                if (score_q != '1) score_d = score_q + SCORE_W'(1);
            end
        end else if (state_q == IDLE) begin
            state_d = PLAY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            lives_q <= LW'(LIVES);
            score_q <= '0;
            grace_q <= '0;
            add_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            score_q <= score_d;
            grace_q <= grace_d;
            add_q   <= add_d;
            hit_q   <= hit_d;
        end
    end

    assign bus.add_point = add_q;
    assign bus.hit       = hit_q;
    assign bus.fail      = (state_q == OVER);
    assign bus.invuln    = (state_q == GRACE);
    assign bus.lives     = lives_q;
    assign bus.score     = score_q;
endmodule

// File: tb/tb_score_judge.sv
// Scoreboard bench: three judge variants share one stimulus stream; expectations are queued per cycle.
module tb_score_judge;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ongoing = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] bird = 8'h10;
    logic [7:0] pipe = 8'h00;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         ids = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    score_judge_if                 if0 ();
    score_judge_if                 if1 ();
    score_judge_if #(.SCORE_W(2))  if2 ();

    assign {if0.ongoing, if0.tick, if0.bird, if0.pipe} = {ongoing, tick, bird, pipe};
    assign {if1.ongoing, if1.tick, if1.bird, if1.pipe} = {ongoing, tick, bird, pipe};
    assign {if2.ongoing, if2.tick, if2.bird, if2.pipe} = {ongoing, tick, bird, pipe};

    score_judge                    u0 (.clk(clk), .reset(reset), .bus(if0));
    score_judge #(.GROUND_FATAL(0)) u1 (.clk(clk), .reset(reset), .bus(if1));
    score_judge #(.SCORE_W(2))     u2 (.clk(clk), .reset(reset), .bus(if2));

    typedef struct {
        int          due;
        int          id;
        int          k;
        logic [15:0] v;   // {add_point, hit, fail, invuln, lives[1:0], score[9:0]}
    } exp_t;

    exp_t q[$];

    function automatic logic [15:0] actual(input int k);
        case (k)
            0:       return {if0.add_point, if0.hit, if0.fail, if0.invuln, if0.lives, if0.score};
            1:       return {if1.add_point, if1.hit, if1.fail, if1.invuln, if1.lives, if1.score};
            default: return {if2.add_point, if2.hit, if2.fail, if2.invuln, if2.lives, 8'd0, if2.score};
        endcase
    endfunction

    // Monitor: pops every expectation due this cycle, flags any that went stale.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                logic [15:0] a;
                e = q.pop_front();
                a = actual(e.k);
                checks++;
                if (e.due != cyc) begin
                    errors++;
                    $display("FAIL chk%0d dut%0d missed sample (due %0d, now %0d)", e.id, e.k, e.due, cyc);
                end else if (a !== e.v) begin
                    errors++;
                    $display("FAIL chk%0d dut%0d got ap=%b hit=%b fail=%b inv=%b lives=%0d score=%0d want ap=%b hit=%b fail=%b inv=%b lives=%0d score=%0d",
                             e.id, e.k, a[15], a[14], a[13], a[12], a[11:10], a[9:0],
                             e.v[15], e.v[14], e.v[13], e.v[12], e.v[11:10], e.v[9:0]);
                end
            end
        end
    end

    task automatic drive(input logic rs, input logic on, input logic tk, input logic [7:0] b, input logic [7:0] p);
        @(negedge clk);
        reset = rs; ongoing = on; tick = tk; bird = b; pipe = p;
    endtask

    task automatic expect_o(input int k, input logic ap, input logic h, input logic f, input logic iv,
                            input logic [1:0] lv, input logic [9:0] sc);
        exp_t e;
        e.due = cyc + 1;
        e.id  = ids++;
        e.k   = k;
        e.v   = {ap, h, f, iv, lv, sc};
        q.push_back(e);
    endtask

    task automatic idle_exp(input int k);
        expect_o(k, 0, 0, 0, 0, 2'd3, 10'd0);
    endtask

    initial begin
        // Reset and idle behaviour
        drive(0, 0, 0, 8'h10, 8'h00); idle_exp(0);
        drive(0, 0, 0, 8'h10, 8'h00); idle_exp(0); idle_exp(1); idle_exp(2);
        drive(1, 0, 1, 8'h10, 8'h00); idle_exp(0);

        // Enter PLAY with a tick in the transition cycle, then score one point
        drive(1, 1, 1, 8'h10, 8'hEF); idle_exp(0);
        drive(1, 1, 1, 8'h10, 8'hEF); idle_exp(0);
        drive(1, 1, 0, 8'h10, 8'h00); idle_exp(0);
        drive(1, 1, 1, 8'h10, 8'h00); expect_o(0, 1, 0, 0, 0, 2'd3, 10'd1);
        drive(1, 1, 0, 8'h10, 8'h00); expect_o(0, 0, 0, 0, 0, 2'd3, 10'd1);

        // Pipe hit, grace window of exactly four ticks, second hit
        drive(1, 1, 1, 8'h10, 8'h10); expect_o(0, 0, 1, 0, 1, 2'd2, 10'd1);
        repeat (3) begin
            drive(1, 1, 1, 8'h10, 8'h10); expect_o(0, 0, 0, 0, 1, 2'd2, 10'd1);
        end
        drive(1, 1, 1, 8'h10, 8'h10); expect_o(0, 0, 0, 0, 0, 2'd2, 10'd1);
        drive(1, 1, 1, 8'h10, 8'h10); expect_o(0, 0, 1, 0, 1, 2'd1, 10'd1);

        // Point during grace, leave grace, fatal last-life hit, frozen OVER
        drive(1, 1, 1, 8'h10, 8'h00); expect_o(0, 1, 0, 0, 1, 2'd1, 10'd2);
        drive(1, 1, 1, 8'h10, 8'h00); expect_o(0, 0, 0, 0, 1, 2'd1, 10'd2);
        drive(1, 1, 1, 8'h10, 8'h00); expect_o(0, 0, 0, 0, 1, 2'd1, 10'd2);
        drive(1, 1, 1, 8'h10, 8'h00); expect_o(0, 0, 0, 0, 0, 2'd1, 10'd2);
        drive(1, 1, 1, 8'h10, 8'h10); expect_o(0, 0, 1, 1, 0, 2'd0, 10'd2);
        drive(1, 1, 1, 8'h10, 8'h10); expect_o(0, 0, 0, 1, 0, 2'd0, 10'd2);
        drive(1, 1, 1, 8'h10, 8'h00); expect_o(0, 0, 0, 1, 0, 2'd0, 10'd2);
        drive(1, 0, 0, 8'h10, 8'h00); idle_exp(0);

        // Ground contact: fatal on dut0 (no point), costs a life on dut1 with simultaneous point
        drive(1, 1, 0, 8'h10, 8'h00); idle_exp(0);
        drive(1, 1, 1, 8'h20, 8'hDF); idle_exp(0); idle_exp(1);
        drive(1, 1, 1, 8'h01, 8'h00);
        expect_o(0, 0, 1, 1, 0, 2'd0, 10'd0);
        expect_o(1, 1, 1, 0, 1, 2'd2, 10'd1);
        drive(1, 0, 0, 8'h10, 8'h00); idle_exp(0); idle_exp(1);

        // Two-bit score saturation on dut2
        drive(1, 1, 0, 8'h10, 8'h00); idle_exp(2);
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 1, 8'h10, 8'hEF); expect_o(2, 0, 0, 0, 0, 2'd3, 10'(i > 3 ? 3 : i - 1));
            drive(1, 1, 1, 8'h10, 8'h00); expect_o(2, 1, 0, 0, 0, 2'd3, 10'(i > 3 ? 3 : i));
        end
        drive(1, 1, 1, 8'h10, 8'h10); expect_o(2, 0, 1, 0, 1, 2'd2, 10'd3);
        drive(1, 1, 1, 8'h10, 8'h00); expect_o(2, 1, 0, 0, 1, 2'd2, 10'd3);

        // Reset mid-grace dominates ongoing and tick
        drive(0, 1, 1, 8'h10, 8'h10); idle_exp(2);
        drive(1, 1, 0, 8'h10, 8'h00); idle_exp(2);
        drive(1, 1, 0, 8'h10, 8'h00);

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain %0d expectations left unchecked, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not end by cycle %0d", cyc);
        $fatal(1);
    end
endmodule
